alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Instruction sequencer for an external combinational ALU: buffers 24-bit instructions in a FIFO,
// issues one per cycle with operand forwarding, and retires results into a 16 x 8-bit register file.
module alu_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic [23:0] instr_in,
  input  logic        stall_in,
  output logic        alu_enable_out,
  output logic [7:0]  alu_opcode_out,
  output logic [7:0]  alu_input1_out,
  output logic [7:0]  alu_input2_out,
  input  logic [7:0]  alu_result_in,
  input  logic [4:0]  alu_flags_in,
  output logic [4:0]  flags_out,
  output logic        retire_valid_out,
  output logic [3:0]  retire_rd_out,
  output logic        illegal_out,
  output logic        busy_out,
  input  logic [3:0]  dbg_addr_in,
  output logic [7:0]  dbg_data_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_EQ   = 8'h03;
  localparam logic [7:0] OP_GT   = 8'h04;
  localparam logic [7:0] OP_ADDI = 8'h09;
  localparam logic [7:0] OP_SUBI = 8'h0A;

  // Flag vector order is {overflow, carry, zero, sign, parity}.
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_SIGN = 1;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  function automatic logic op_is_legal(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_ADDI, OP_SUBI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_compare(input logic [7:0] op);
    return (op == OP_EQ) || (op == OP_GT);
  endfunction

  function automatic logic op_uses_imm(input logic [7:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // Handshake: instr_in is taken on every rising edge where instr_valid_in and
  // instr_ready_out are both high. instr_ready_out depends only on reset and FIFO
  // occupancy, never on instr_valid_in or on a pop in the same cycle.
  // ---------------------------------------------------------------------------
  logic [23:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;

  assign fifo_empty      = (count == '0);
  assign fifo_full       = (count == FULL_COUNT);
  assign instr_ready_out = reset_in && !fifo_full;
  assign push            = instr_valid_in && instr_ready_out;
  assign pop             = !stall_in && !fifo_empty;

  always_ff @(posedge clock_in) begin
    if (push) begin
      fifo_mem[wr_ptr] <= instr_in;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Issue/execute FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pop) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (!stall_in) begin
          next_state = pop ? EXEC : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign alu_enable_out = (state == EXEC);
  assign busy_out       = !fifo_empty || (state == EXEC);

  // ---------------------------------------------------------------------------
  // Operand fetch with forwarding from the writeback happening at the same edge
  // ---------------------------------------------------------------------------
  logic [7:0]  regs [16];
  logic [3:0]  wb_rd;
  logic        wb_fire;
  logic        wb_legal;
  logic [23:0] head;
  logic [7:0]  head_op;
  logic [3:0]  head_rd;
  logic [3:0]  head_rs1;
  logic [3:0]  head_rs2;
  logic [7:0]  head_imm;
  logic [7:0]  src1;
  logic [7:0]  src2;

  assign head     = fifo_mem[rd_ptr];
  assign head_op  = head[23:16];
  assign head_rd  = head[15:12];
  assign head_rs1 = head[11:8];
  assign head_imm = head[7:0];
  assign head_rs2 = head[3:0];

  assign wb_fire  = (state == EXEC) && !stall_in;
  // Illegal instructions never write, so they must not be forwarded either.
  assign wb_legal = wb_fire && op_is_legal(alu_opcode_out);

  always_comb begin
    src1 = regs[head_rs1];
    src2 = regs[head_rs2];
    if (wb_legal && (wb_rd == head_rs1)) begin
      src1 = alu_result_in;
    end
    if (wb_legal && (wb_rd == head_rs2)) begin
      src2 = alu_result_in;
    end
    if (op_uses_imm(head_op)) begin
      src2 = head_imm;
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      alu_opcode_out <= '0;
      alu_input1_out <= '0;
      alu_input2_out <= '0;
      wb_rd          <= '0;
    end else if (pop) begin
      alu_opcode_out <= head_op;
      alu_input1_out <= src1;
      alu_input2_out <= src2;
      wb_rd          <= head_rd;
    end else if (wb_fire) begin
      alu_opcode_out <= '0;
      alu_input1_out <= '0;
      alu_input2_out <= '0;
      wb_rd          <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback, flags and retire
  // ---------------------------------------------------------------------------
  logic [4:0] flags_next;

  always_comb begin
    flags_next = alu_flags_in;
    if (op_is_compare(alu_opcode_out)) begin
      flags_next            = flags_out;
      flags_next[FLAG_ZERO] = alu_flags_in[FLAG_ZERO];
      flags_next[FLAG_SIGN] = alu_flags_in[FLAG_SIGN];
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= '0;
      end
      flags_out        <= '0;
      illegal_out      <= 1'b0;
      retire_valid_out <= 1'b0;
      retire_rd_out    <= '0;
    end else begin
      retire_valid_out <= wb_fire;
      if (wb_fire) begin
        retire_rd_out <= wb_rd;
        if (wb_legal) begin
          regs[wb_rd] <= alu_result_in;
          flags_out   <= flags_next;
        end else begin
          illegal_out <= 1'b1;
        end
      end
    end
  end

  assign dbg_data_out = regs[dbg_addr_in];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU, ISA-level register model, retire scoreboard,
// table-driven vectors plus hand sequences for latency, stall back-pressure and reset mid-EXEC.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        instr_valid_in;
  logic        instr_ready_out;
  logic [23:0] instr_in;
  logic        stall_in;
  logic        alu_enable_out;
  logic [7:0]  alu_opcode_out;
  logic [7:0]  alu_input1_out;
  logic [7:0]  alu_input2_out;
  logic [7:0]  alu_result_in;
  logic [4:0]  alu_flags_in;
  logic [4:0]  flags_out;
  logic        retire_valid_out;
  logic [3:0]  retire_rd_out;
  logic        illegal_out;
  logic        busy_out;
  logic [3:0]  dbg_addr_in;
  logic [7:0]  dbg_data_out;

  logic [3:0]  main_addr;
  logic [3:0]  mon_addr;
  logic        mon_active;

  int checks = 0;
  int failures = 0;

  // Expected retire record: {rd[17:14], value[13:6], flags[5:1], illegal[0]}
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;

  logic [7:0]  mregs [16];
  logic [4:0]  mflags;
  logic        mill;

  typedef struct {
    logic [23:0] ins;
    logic [3:0]  rd;
    logic [7:0]  val;
    logic [4:0]  flg;
    logic        ill;
  } vec_t;

  vec_t vecs [11];

  alu_sequencer #(.FIFO_DEPTH(4)) dut (
    .clock_in         (clk),
    .reset_in         (reset_in),
    .instr_valid_in   (instr_valid_in),
    .instr_ready_out  (instr_ready_out),
    .instr_in         (instr_in),
    .stall_in         (stall_in),
    .alu_enable_out   (alu_enable_out),
    .alu_opcode_out   (alu_opcode_out),
    .alu_input1_out   (alu_input1_out),
    .alu_input2_out   (alu_input2_out),
    .alu_result_in    (alu_result_in),
    .alu_flags_in     (alu_flags_in),
    .flags_out        (flags_out),
    .retire_valid_out (retire_valid_out),
    .retire_rd_out    (retire_rd_out),
    .illegal_out      (illegal_out),
    .busy_out         (busy_out),
    .dbg_addr_in      (dbg_addr_in),
    .dbg_data_out     (dbg_data_out)
  );

  always #5 clk = ~clk;

  assign dbg_addr_in = mon_active ? mon_addr : main_addr;

  // Behavioural ALU: returns {overflow, carry, zero, sign, parity, result}.
  function automatic logic [12:0] alu_calc(input logic [7:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = '0;
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      8'h00, 8'h09: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      8'h01, 8'h0A: begin
        r = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      8'h03: r = (a == b) ? 8'd1 : 8'd0;
      8'h04: r = (a > b) ? 8'd1 : 8'd0;
      default: return {5'b11111, 8'hA5};
    endcase
    return {v, c, (r == 8'd0), r[7], ^r, r};
  endfunction

  logic [12:0] alu_bus;
  always_comb alu_bus = alu_calc(alu_opcode_out, alu_input1_out, alu_input2_out);
  assign alu_result_in = alu_bus[7:0];
  assign alu_flags_in  = alu_bus[12:8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mregs[i] = '0;
    end
    mflags = '0;
    mill   = 1'b0;
  endtask

  // Sequential ISA semantics: each accepted instruction executes in order.
  task automatic model_exec(input logic [23:0] ins, output logic [17:0] e);
    logic [7:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [12:0] res;
    op  = ins[23:16];
    a   = mregs[ins[11:8]];
    b   = (op == 8'h09 || op == 8'h0A) ? ins[7:0] : mregs[ins[3:0]];
    res = alu_calc(op, a, b);
    case (op)
      8'h00, 8'h01, 8'h09, 8'h0A: begin
        mregs[ins[15:12]] = res[7:0];
        mflags = res[12:8];
      end
      8'h03, 8'h04: begin
        mregs[ins[15:12]] = res[7:0];
        mflags[2] = res[10];
        mflags[1] = res[9];
      end
      default: mill = 1'b1;
    endcase
    e = {ins[15:12], mregs[ins[15:12]], mflags, mill};
  endtask

  task automatic send(input logic [23:0] ins, input logic [17:0] e, input bit rand_stall);
    int guard;
    guard = 0;
    @(negedge clk);
    if (rand_stall) stall_in = ($urandom_range(0, 3) == 0);
    instr_valid_in = 1'b1;
    instr_in = ins;
    while (!instr_ready_out && guard < 100) begin
      @(negedge clk);
      guard++;
      if (rand_stall) stall_in = ($urandom_range(0, 3) == 0);
    end
    if (guard >= 100) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: instr 0x%06h never accepted", ins);
      instr_valid_in = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    @(negedge clk);
    instr_valid_in = 1'b0;
    stall_in = 1'b0;
    while ((busy_out || retire_valid_out || exp_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: busy=%0b pending=%0d", busy_out, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic compare_model(input string tag);
    for (int i = 0; i < 16; i++) begin
      main_addr = 4'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), 32'(dbg_data_out), 32'(mregs[i]));
    end
    check({tag, "_flags"}, 32'(flags_out), 32'(mflags));
    check({tag, "_illegal"}, 32'(illegal_out), 32'(mill));
  endtask

  // Scoreboard: every retire pulse must match the oldest expected record.
  always @(negedge clk) begin
    if (reset_in && retire_valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire: rd=%0d with nothing pending at %0t", retire_rd_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_addr = mon_e[17:14];
        mon_active = 1'b1;
        #1;
        check("retire_rd", 32'(retire_rd_out), 32'(mon_e[17:14]));
        check("retire_value", 32'(dbg_data_out), 32'(mon_e[13:6]));
        check("retire_flags", 32'(flags_out), 32'(mon_e[5:1]));
        check("retire_illegal", 32'(illegal_out), 32'(mon_e[0]));
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] e;
    logic [23:0] ins;
    logic [7:0]  ops [8];
    bit          acc;
    int          accepted;
    int          nret;
    int          ret_cyc [4];

    reset_in       = 1'b0;
    instr_valid_in = 1'b0;
    instr_in       = '0;
    stall_in       = 1'b0;
    main_addr      = '0;
    mon_addr       = '0;
    mon_active     = 1'b0;
    model_reset();

    vecs[0]  = '{24'h013001, 4'h3, 8'hFB, 5'b01011, 1'b0};
    vecs[1]  = '{24'h09107F, 4'h1, 8'h7F, 5'b00001, 1'b0};
    vecs[2]  = '{24'h002101, 4'h2, 8'hFE, 5'b10011, 1'b0};
    vecs[3]  = '{24'h034102, 4'h4, 8'h00, 5'b10101, 1'b0};
    vecs[4]  = '{24'h045201, 4'h5, 8'h01, 5'b10001, 1'b0};
    vecs[5]  = '{24'h0A6210, 4'h6, 8'hEE, 5'b00010, 1'b0};
    vecs[6]  = '{24'h027101, 4'h7, 8'h00, 5'b00010, 1'b1};
    vecs[7]  = '{24'h09A701, 4'hA, 8'h01, 5'b00001, 1'b1};
    vecs[8]  = '{24'h018606, 4'h8, 8'h00, 5'b00100, 1'b1};
    vecs[9]  = '{24'h009608, 4'h9, 8'hEE, 5'b00010, 1'b1};
    vecs[10] = '{24'h00B202, 4'hB, 8'hFC, 5'b01010, 1'b1};

    ops[0] = 8'h00; ops[1] = 8'h01; ops[2] = 8'h03; ops[3] = 8'h04;
    ops[4] = 8'h09; ops[5] = 8'h0A; ops[6] = 8'h02; ops[7] = 8'h5C;

    // Reset state
    repeat (3) @(negedge clk);
    check("ready_during_reset", 32'(instr_ready_out), 32'd0);
    reset_in = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(instr_ready_out), 32'd1);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_enable", 32'(alu_enable_out), 32'd0);
    check("reset_retire", 32'(retire_valid_out), 32'd0);
    check("reset_opcode", 32'(alu_opcode_out), 32'd0);
    compare_model("reset");

    // Single ADDI from empty FIFO: accept N, issue N+1, writeback N+2, retire after N+2
    model_exec(24'h091005, e);
    @(negedge clk);
    instr_valid_in = 1'b1;
    instr_in = 24'h091005;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    instr_valid_in = 1'b0;
    check("lat_accept_enable", 32'(alu_enable_out), 32'd0);
    check("lat_accept_busy", 32'(busy_out), 32'd1);
    @(negedge clk);
    check("lat_issue_enable", 32'(alu_enable_out), 32'd1);
    check("lat_issue_opcode", 32'(alu_opcode_out), 32'h09);
    check("lat_issue_in1", 32'(alu_input1_out), 32'h00);
    check("lat_issue_in2", 32'(alu_input2_out), 32'h05);
    check("lat_issue_retire", 32'(retire_valid_out), 32'd0);
    @(negedge clk);
    check("lat_retire_pulse", 32'(retire_valid_out), 32'd1);
    check("lat_retire_enable", 32'(alu_enable_out), 32'd0);
    check("lat_retire_opcode", 32'(alu_opcode_out), 32'd0);
    drain();

    // Table vectors, issued back-to-back to exercise forwarding and illegal handling
    for (int i = 0; i < 11; i++) begin
      model_exec(vecs[i].ins, e);
      send(vecs[i].ins, {vecs[i].rd, vecs[i].val, vecs[i].flg, vecs[i].ill}, 1'b0);
    end
    drain();
    compare_model("table");
    check("illegal_sticky", 32'(illegal_out), 32'd1);

    // Stall back-pressure: 5 offered, 4 accepted, then 4 consecutive retires
    @(negedge clk);
    stall_in = 1'b1;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      instr_valid_in = 1'b1;
      instr_in = {8'h09, 4'hC, 4'hC, 8'(i + 1)};
      acc = instr_ready_out;
      @(posedge clk);
      if (acc) begin
        model_exec(instr_in, e);
        exp_q.push_back(e);
        accepted++;
      end
      @(negedge clk);
    end
    instr_valid_in = 1'b0;
    check("stall_accepted", 32'(accepted), 32'd4);
    check("stall_ready", 32'(instr_ready_out), 32'd0);
    check("stall_busy", 32'(busy_out), 32'd1);
    check("stall_no_issue", 32'(alu_enable_out), 32'd0);
    stall_in = 1'b0;
    nret = 0;
    for (int k = 0; k < 4; k++) ret_cyc[k] = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (retire_valid_out) begin
        if (nret < 4) ret_cyc[nret] = c;
        nret++;
      end
    end
    check("stall_retire_count", 32'(nret), 32'd4);
    check("stall_first_retire", 32'(ret_cyc[0]), 32'd2);
    for (int k = 1; k < 4; k++) begin
      check("stall_consecutive", 32'(ret_cyc[k]), 32'(ret_cyc[0] + k));
    end
    drain();
    compare_model("stall");

    // Random traffic with random stalls and gaps
    for (int n = 0; n < 60; n++) begin
      ins = {ops[$urandom_range(0, 7)], 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
             8'($urandom_range(0, 255))};
      model_exec(ins, e);
      send(ins, e, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        instr_valid_in = 1'b0;
      end
    end
    drain();
    compare_model("random");

    // Reset while ADDI R4 is in EXEC with another instruction queued
    model_exec(24'h094033, e);
    send(24'h094033, e, 1'b0);
    model_exec(24'h095011, e);
    send(24'h095011, e, 1'b0);
    @(negedge clk);
    instr_valid_in = 1'b0;
    check("rst_exec_enable", 32'(alu_enable_out), 32'd1);
    check("rst_exec_opcode", 32'(alu_opcode_out), 32'h09);
    check("rst_exec_in2", 32'(alu_input2_out), 32'h33);
    reset_in = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    main_addr = 4'h4;
    #1;
    check("rst_r4", 32'(dbg_data_out), 32'd0);
    check("rst_retire", 32'(retire_valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_ready_low", 32'(instr_ready_out), 32'd0);
    check("rst_enable", 32'(alu_enable_out), 32'd0);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_illegal", 32'(illegal_out), 32'd0);
    repeat (2) @(negedge clk);
    reset_in = 1'b1;
    @(negedge clk);
    check("rst_ready_after", 32'(instr_ready_out), 32'd1);
    repeat (5) @(negedge clk);
    check("rst_busy_after", 32'(busy_out), 32'd0);
    compare_model("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
